// File: rtl/stopwatch_digit_counter_pkg.sv
// Shared types and constants for the MM:SS.cc stopwatch core.
// Digit indices follow the HEX0..HEX5 display order.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } sw_state_e;

  localparam int unsigned DIG_LIMIT_UNITS = 9;
  localparam int unsigned DIG_LIMIT_TENS  = 5;

  localparam int unsigned NUM_DIGITS  = 6;
  localparam int unsigned DIG_CS_ONES = 0;
  localparam int unsigned DIG_CS_TENS = 1;
  localparam int unsigned DIG_S_ONES  = 2;
  localparam int unsigned DIG_S_TENS  = 3;
  localparam int unsigned DIG_M_ONES  = 4;
  localparam int unsigned DIG_M_TENS  = 5;

  localparam int unsigned KEY_SS  = 0;
  localparam int unsigned KEY_CLR = 1;

  function automatic int unsigned digit_limit(input int unsigned idx);
    return (idx == DIG_S_TENS || idx == DIG_M_TENS) ? DIG_LIMIT_TENS : DIG_LIMIT_UNITS;
  endfunction

endpackage

// File: rtl/stopwatch_digit_counter_if.sv
// Key inputs and BCD digit / status outputs of the stopwatch core.
// master = stopwatch core, slave = key source and display decoders.
interface stopwatch_digit_counter_if;
  logic       key_start_stop_n;
  logic       key_clear_n;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [3:0] digit4;
  logic [3:0] digit5;
  logic       running;
  logic       wrap;

  modport master (
    input  key_start_stop_n, key_clear_n,
    output digit0, digit1, digit2, digit3, digit4, digit5, running, wrap
  );

  modport slave (
    output key_start_stop_n, key_clear_n,
    input  digit0, digit1, digit2, digit3, digit4, digit5, running, wrap
  );
endinterface

// File: rtl/stopwatch_digit_counter_bcd_digit.sv
// One BCD digit counting 0..MAX; carry is combinational so a whole cascade
// advances on a single edge. No backpressure: inc is acted on every cycle.
module bcd_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  localparam logic [3:0] MAX_V = 4'(MAX);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc) begin
      q_d = (q_q == MAX_V) ? 4'd0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q     = q_q;
  assign carry = inc && (q_q == MAX_V);

endmodule

// File: rtl/stopwatch_digit_counter.sv
// Stopwatch core: key conditioning, run/pause FSM, prescaler and six-digit BCD cascade.
// Key press to state change 3 edges; digits/wrap update on the edge ending a tick; no backpressure.
module stopwatch_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic                        clk,
  input  logic                        reset_n,
  stopwatch_digit_counter_if.master   bus
);

  localparam int unsigned     DIV      = CLK_HZ / TICK_HZ;
  localparam int unsigned     PW       = $clog2(DIV);
  localparam logic [PW-1:0]   PRE_TERM = PW'(DIV - 1);

  logic [1:0] key_n;
  logic [1:0] meta_q, sync_q, hist_q, ev_q;
  logic       ev_ss, ev_clr;

  assign key_n = {bus.key_clear_n, bus.key_start_stop_n};

  // Event pulse is registered so a press reaches the FSM on the third edge after first sampling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '1;
      sync_q <= '1;
      hist_q <= '1;
      ev_q   <= '0;
    end else begin
      meta_q <= key_n;
      sync_q <= meta_q;
      hist_q <= sync_q;
      ev_q   <= hist_q & ~sync_q;
    end
  end

  assign ev_ss  = ev_q[KEY_SS];
  assign ev_clr = ev_q[KEY_CLR];

  sw_state_e             state_q;
  logic                  running_q;
  logic                  wrap_q;
  logic [PW-1:0]         pre_q, pre_d;
  logic                  tick;
  logic [3:0]            dig   [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] inc;

  assign tick = (state_q == ST_RUN) && (pre_q == PRE_TERM);

  // PAUSE holds the prescaler so a resumed run keeps its partial tick.
  always_comb begin
    pre_d = pre_q;
    if (ev_clr || state_q == ST_IDLE) begin
      pre_d = '0;
    end else if (state_q == ST_RUN) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      pre_q     <= '0;
    end else begin
      pre_q  <= pre_d;
      wrap_q <= carry[NUM_DIGITS-1] && !ev_clr;
      if (ev_clr) begin
        state_q   <= ST_IDLE;
        running_q <= 1'b0;
      end else if (ev_ss) begin
        case (state_q)
          ST_RUN: begin
            state_q   <= ST_PAUSE;
            running_q <= 1'b0;
          end
          ST_IDLE, ST_PAUSE: begin
            state_q   <= ST_RUN;
            running_q <= 1'b1;
          end
          default: begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign inc = {carry[NUM_DIGITS-2:0], tick};

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit #(.MAX(digit_limit(i))) u_dig (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (ev_clr),
      .inc     (inc[i]),
      .q       (dig[i]),
      .carry   (carry[i])
    );
  end

  assign bus.digit0  = dig[DIG_CS_ONES];
  assign bus.digit1  = dig[DIG_CS_TENS];
  assign bus.digit2  = dig[DIG_S_ONES];
  assign bus.digit3  = dig[DIG_S_TENS];
  assign bus.digit4  = dig[DIG_M_ONES];
  assign bus.digit5  = dig[DIG_M_TENS];
  assign bus.running = running_q;
  assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_digit_counter.sv
// Bench for stopwatch_digit_counter: elapsed time kept as plain centiseconds,
// keys modelled as events landing three edges after the first low sample.
module tb_stopwatch_digit_counter;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int FULL_CS = 60 * 60 * 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [23:0] force_val = '0;

  int checks = 0;
  int errors = 0;

  int       m_cs, m_phase;
  bit       m_run, m_wrap, m_prev_ss, m_prev_clr;
  bit [2:0] m_pend_ss, m_pend_clr;

  stopwatch_digit_counter_if bus ();

  stopwatch_digit_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] exp_digits(input int cs);
    logic [23:0] d;
    d = {4'(cs / 60000 % 6), 4'(cs / 6000 % 10), 4'(cs / 1000 % 6),
         4'(cs / 100 % 10), 4'(cs / 10 % 10), 4'(cs % 10)};
    return d;
  endfunction

  function automatic logic [23:0] dut_digits();
    return {bus.digit5, bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0};
  endfunction

  task automatic model_reset();
    m_cs = 0; m_phase = 0; m_run = 0; m_wrap = 0;
    m_prev_ss = 1; m_prev_clr = 1; m_pend_ss = '0; m_pend_clr = '0;
  endtask

  // One clock edge of the reference: count RUN clocks, then apply key events.
  task automatic model_edge();
    bit ap_ss, ap_clr;
    ap_ss  = m_pend_ss[2];
    ap_clr = m_pend_clr[2];
    m_pend_ss  = {m_pend_ss[1:0],  m_prev_ss  && !bus.key_start_stop_n};
    m_pend_clr = {m_pend_clr[1:0], m_prev_clr && !bus.key_clear_n};
    m_prev_ss  = bus.key_start_stop_n;
    m_prev_clr = bus.key_clear_n;
    m_wrap = 0;
    if (m_run) begin
      m_phase++;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_cs = (m_cs + 1) % FULL_CS;
        m_wrap = (m_cs == 0);
      end
    end
    if (ap_clr) begin
      m_cs = 0; m_phase = 0; m_run = 0; m_wrap = 0;
    end else if (ap_ss) begin
      m_run = !m_run;
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
    end
  endtask

  task automatic press(input bit ss, input bit clr, input int hold);
    bus.key_start_stop_n = !ss;
    bus.key_clear_n      = !clr;
    step(hold);
    bus.key_start_stop_n = 1'b1;
    bus.key_clear_n      = 1'b1;
  endtask

  task automatic preload(input logic [23:0] v, input int cs);
    force_val = v;
    force dut.g_dig[0].u_dig.q_q = force_val[3:0];
    force dut.g_dig[1].u_dig.q_q = force_val[7:4];
    force dut.g_dig[2].u_dig.q_q = force_val[11:8];
    force dut.g_dig[3].u_dig.q_q = force_val[15:12];
    force dut.g_dig[4].u_dig.q_q = force_val[19:16];
    force dut.g_dig[5].u_dig.q_q = force_val[23:20];
    step(2);
    release dut.g_dig[0].u_dig.q_q;
    release dut.g_dig[1].u_dig.q_q;
    release dut.g_dig[2].u_dig.q_q;
    release dut.g_dig[3].u_dig.q_q;
    release dut.g_dig[4].u_dig.q_q;
    release dut.g_dig[5].u_dig.q_q;
    m_cs = cs;
  endtask

  task automatic test_reset();
    logic [25:0] obs, exp;
    bus.key_start_stop_n = 1'b1;
    bus.key_clear_n      = 1'b1;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({dut_digits(), bus.running, bus.wrap} !== 26'd0) begin
      errors++;
      $display("FAIL reset_hold: got %h required 0", {dut_digits(), bus.running, bus.wrap});
    end
    reset_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle cyc %0d: got %h required %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_start();
    logic [25:0] obs, exp;
    int cnt;
    bus.key_start_stop_n = 1'b0;
    for (int i = 0; i < 250; i++) begin
      if (i == 5) bus.key_start_stop_n = 1'b1;
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL start cyc %0d: got %h required %h", i, obs, exp);
      end
    end
    cnt = int'(bus.digit1) * 10 + int'(bus.digit0);
    checks++;
    if (cnt < 24 || cnt > 26 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL start_count: got cs=%0d running=%b required 24..26 running=1", cnt, bus.running);
    end
  endtask

  task automatic test_pause();
    logic [25:0] obs, exp;
    logic [23:0] prev, frozen;
    bit got, measured;
    int d, runs;
    prev = dut_digits();
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (dut_digits() !== prev) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL pause_tick_seen: got no tick in 20 cycles required one");
    end
    d = $urandom_range(1, 7);
    runs = int'(bus.running);
    prev = dut_digits();
    frozen = prev;
    measured = 0;
    for (int i = 1; i <= 280; i++) begin
      if (i == d)       bus.key_start_stop_n = 1'b0;
      if (i == d + 200) bus.key_start_stop_n = 1'b1;
      if (i == d + 230) bus.key_start_stop_n = 1'b0;
      if (i == d + 233) bus.key_start_stop_n = 1'b1;
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL pause cyc %0d: got %h required %h", i, obs, exp);
      end
      if (!measured) begin
        if (dut_digits() !== prev) begin
          measured = 1;
          checks++;
          if (runs != DIV) begin
            errors++;
            $display("FAIL pause_tick_period: got %0d run clocks required %0d", runs, DIV);
          end
        end else begin
          runs += int'(bus.running);
        end
      end
      if (i == d + 10) frozen = dut_digits();
      if (i == d + 200) begin
        checks++;
        if (dut_digits() !== frozen || bus.running !== 1'b0) begin
          errors++;
          $display("FAIL pause_frozen: got %h run=%b required %h run=0", dut_digits(), bus.running, frozen);
        end
      end
    end
    checks++;
    if (!measured) begin
      errors++;
      $display("FAIL pause_resume_tick: got no tick after resume required one");
    end
  endtask

  task automatic test_ss_on_tick();
    logic [25:0] obs, exp;
    logic [23:0] prev;
    bit got;
    prev = dut_digits();
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1);
      if (dut_digits() !== prev) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL ss_tick_seen: got no tick in 20 cycles required one");
    end
    prev = dut_digits();
    for (int i = 1; i <= 30; i++) begin
      if (i == 7)  bus.key_start_stop_n = 1'b0;
      if (i == 10) bus.key_start_stop_n = 1'b1;
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL ss_on_tick cyc %0d: got %h required %h", i, obs, exp);
      end
    end
    checks++;
    if (bus.running !== 1'b0 || dut_digits() === prev) begin
      errors++;
      $display("FAIL ss_on_tick_final: got %h run=%b required advanced from %h run=0",
               dut_digits(), bus.running, prev);
    end
  endtask

  task automatic test_wrap();
    logic [25:0] obs, exp;
    logic [23:0] prev;
    int nwrap;
    if (m_run) press(1, 0, 3);
    step(6);
    preload(24'h595998, FULL_CS - 2);
    checks++;
    if (dut_digits() !== 24'h595998) begin
      errors++;
      $display("FAIL wrap_preload: got %h required 595998", dut_digits());
    end
    nwrap = 0;
    prev = dut_digits();
    for (int i = 0; i < 40; i++) begin
      bus.key_start_stop_n = (i < 3) ? 1'b0 : 1'b1;
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap cyc %0d: got %h required %h", i, obs, exp);
      end
      if (bus.wrap === 1'b1) begin
        nwrap++;
        checks++;
        if (dut_digits() !== 24'h0 || bus.running !== 1'b1 || prev !== 24'h595999) begin
          errors++;
          $display("FAIL wrap_point: got %h (prev %h) run=%b required 000000 (prev 595999) run=1",
                   dut_digits(), prev, bus.running);
        end
      end
      prev = dut_digits();
    end
    checks++;
    if (nwrap != 1) begin
      errors++;
      $display("FAIL wrap_pulses: got %0d required 1", nwrap);
    end
  endtask

  task automatic test_both_keys();
    logic [25:0] obs, exp;
    step($urandom_range(1, 9));
    press(1, 1, 4);
    for (int i = 0; i < 15; i++) begin
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL both_keys cyc %0d: got %h required %h", i, obs, exp);
      end
    end
    checks++;
    if ({dut_digits(), bus.running} !== 25'd0) begin
      errors++;
      $display("FAIL both_keys_idle: got %h run=%b required 000000 run=0", dut_digits(), bus.running);
    end
  endtask

  task automatic test_async_reset();
    logic [25:0] obs, exp;
    press(1, 0, 3);
    step(8);
    press(1, 0, 3);
    step(6);
    preload(24'h123456, 12 * 6000 + 34 * 100 + 56);
    press(1, 0, 2);
    step(2);
    checks++;
    if (dut_digits() !== 24'h123456 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got %h run=%b required 123456 run=1", dut_digits(), bus.running);
    end
    @(posedge clk);
    model_edge();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({dut_digits(), bus.running, bus.wrap} !== 26'd0) begin
      errors++;
      $display("FAIL areset_immediate: got %h required 0", {dut_digits(), bus.running, bus.wrap});
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 80; i++) begin
      if (i == 50) bus.key_start_stop_n = 1'b0;
      if (i == 55) bus.key_start_stop_n = 1'b1;
      step(1);
      obs = {dut_digits(), bus.running, bus.wrap};
      exp = {exp_digits(m_cs), m_run, m_wrap};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL areset_after cyc %0d: got %h required %h", i, obs, exp);
      end
      if (i == 49) begin
        checks++;
        if ({dut_digits(), bus.running} !== 25'd0) begin
          errors++;
          $display("FAIL areset_no_count: got %h run=%b required 000000 run=0", dut_digits(), bus.running);
        end
      end
    end
    checks++;
    if (dut_digits() === 24'h0 || bus.running !== 1'b1) begin
      errors++;
      $display("FAIL areset_restart: got %h run=%b required nonzero run=1", dut_digits(), bus.running);
    end
  endtask

  task automatic test_random();
    logic [25:0] obs, exp;
    int r, hold, gap;
    bit ss, clr;
    for (int op = 0; op < 60; op++) begin
      r    = $urandom_range(0, 99);
      ss   = (r < 70) || (r >= 95);
      clr  = (r >= 70 && r < 85) || (r >= 95);
      hold = $urandom_range(1, 12);
      gap  = $urandom_range(3, 70);
      for (int c = 0; c < hold + gap; c++) begin
        bus.key_start_stop_n = !(ss  && c < hold);
        bus.key_clear_n      = !(clr && c < hold);
        step(1);
        obs = {dut_digits(), bus.running, bus.wrap};
        exp = {exp_digits(m_cs), m_run, m_wrap};
        checks++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random op %0d cyc %0d: got %h required %h", op, c, obs, exp);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause();
    test_ss_on_tick();
    test_wrap();
    test_both_keys();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
